// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   - HZ_ST_* : hazard FSM state encodings
//   - MUX_EX_REDIR_{A,B}_* : forwarding select codes latched into ID/EX
//   - hz_slot_t : one in-flight destination-register record
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_BIT = 5;

    // FSM encodings kept as plain constants so legacy decoders can share them.
    localparam int unsigned HZ_ST_BIT = 2;
    localparam logic [HZ_ST_BIT-1:0] HZ_ST_RUN     = 2'd0;
    localparam logic [HZ_ST_BIT-1:0] HZ_ST_HALTING = 2'd1;
    localparam logic [HZ_ST_BIT-1:0] HZ_ST_HALTED  = 2'd2;

    // Forwarding mux select codes for operand A and operand B.
    localparam int unsigned MUX_EX_REDIR_DATAA_BIT = 2;
    localparam int unsigned MUX_EX_REDIR_DATAB_BIT = 2;
    localparam logic [MUX_EX_REDIR_DATAA_BIT-1:0] MUX_EX_REDIR_A_OLD = 2'd0;
    localparam logic [MUX_EX_REDIR_DATAA_BIT-1:0] MUX_EX_REDIR_A_EX  = 2'd1;
    localparam logic [MUX_EX_REDIR_DATAA_BIT-1:0] MUX_EX_REDIR_A_DM  = 2'd2;
    localparam logic [MUX_EX_REDIR_DATAB_BIT-1:0] MUX_EX_REDIR_B_OLD = 2'd0;
    localparam logic [MUX_EX_REDIR_DATAB_BIT-1:0] MUX_EX_REDIR_B_EX  = 2'd1;
    localparam logic [MUX_EX_REDIR_DATAB_BIT-1:0] MUX_EX_REDIR_B_DM  = 2'd2;

    // Where an ID-stage operand should be taken from.
    typedef enum logic [1:0] {
        SRC_OLD = 2'd0,
        SRC_EX  = 2'd1,
        SRC_DM  = 2'd2
    } hz_src_e;

    // In-flight writer record; valid implies a real write to a non-zero register.
    typedef struct packed {
        logic               valid;
        logic [REG_BIT-1:0] req_w;
        logic               is_load;
    } hz_slot_t;

    // True when the slot holds a pending write to register r.
    function automatic logic slot_hit(hz_slot_t s, logic [REG_BIT-1:0] r);
        return s.valid && (s.req_w == r);
    endfunction

    // Youngest writer wins; a WB-only match reads the write-through register file.
    function automatic hz_src_e fwd_pick(logic used, logic ex_hit, logic dm_hit, logic wb_hit);
        if (!used)       return SRC_OLD;
        else if (ex_hit) return SRC_EX;
        else if (dm_hit) return SRC_DM;
        else if (wb_hit) return SRC_OLD;
        else             return SRC_OLD;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot (EX, DM, WB) shift register of in-flight destination registers.
//   clk, rst, en   : clock, synchronous active-high reset, advance enable
//   id_slot        : record entering EX (valid already cleared for bubbles)
//   rs, rt         : ID-stage source register numbers to match
//   ex_hit_*/dm_hit_*/wb_hit_* : per-source match against each slot
//   ex_load        : EX slot holds a valid load
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  hz_slot_t           id_slot,
    input  logic [REG_BIT-1:0] rs,
    input  logic [REG_BIT-1:0] rt,
    output logic               ex_hit_a,
    output logic               ex_hit_b,
    output logic               dm_hit_a,
    output logic               dm_hit_b,
    output logic               wb_hit_a,
    output logic               wb_hit_b,
    output logic               ex_load
);

    hz_slot_t ex_slot;
    hz_slot_t dm_slot;
    hz_slot_t wb_slot;
    hz_slot_t push_slot;

    // Writes to $0 never need tracking; store them as empty slots.
    always_comb begin
        push_slot = '0;
        if (id_slot.valid && (id_slot.req_w != '0)) begin
            push_slot = id_slot;
        end
    end

    // Slots advance together with the pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot <= '0;
            dm_slot <= '0;
            wb_slot <= '0;
        end else if (en) begin
            wb_slot <= dm_slot;
            dm_slot <= ex_slot;
            ex_slot <= push_slot;
        end
    end

    assign ex_hit_a = slot_hit(ex_slot, rs);
    assign ex_hit_b = slot_hit(ex_slot, rt);
    assign dm_hit_a = slot_hit(dm_slot, rs);
    assign dm_hit_b = slot_hit(dm_slot, rt);
    assign wb_hit_a = slot_hit(wb_slot, rs);
    assign wb_hit_b = slot_hit(wb_slot, rt);
    assign ex_load  = ex_slot.valid && ex_slot.is_load;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage IF/ID/EX/DM/WB pipeline.
//   clk, rst, en         : clock, synchronous active-high reset, global run enable
//   id_*                 : decoded fields of the instruction currently in ID
//   load_pc              : EX-stage taken jump/branch
//   halt_ex, halt_wb     : syscall halt resolved in EX / reached DM-WB output
//   pc_en, if_id_*, id_ex_* : pipeline register enable/clear controls
//   fwd_a, fwd_b         : operand forwarding selects latched into ID/EX
//   halted               : sticky halt indication
//   stall_cnt, flush_cnt : saturating load-use stall / flush counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_BIT = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [REG_BIT-1:0]                id_rs,
    input  logic [REG_BIT-1:0]                id_rt,
    input  logic                              id_use_a,
    input  logic                              id_use_b,
    input  logic                              id_w_en,
    input  logic [REG_BIT-1:0]                id_req_w,
    input  logic                              id_is_load,
    input  logic                              load_pc,
    input  logic                              halt_ex,
    input  logic                              halt_wb,
    output logic                              pc_en,
    output logic                              if_id_en,
    output logic                              if_id_clr,
    output logic                              id_ex_en,
    output logic                              id_ex_clr,
    output logic [MUX_EX_REDIR_DATAA_BIT-1:0] fwd_a,
    output logic [MUX_EX_REDIR_DATAB_BIT-1:0] fwd_b,
    output logic                              halted,
    output logic [CNT_BIT-1:0]                stall_cnt,
    output logic [CNT_BIT-1:0]                flush_cnt
);

    logic [HZ_ST_BIT-1:0] state;
    logic [HZ_ST_BIT-1:0] state_nxt;

    logic     ex_hit_a, ex_hit_b;
    logic     dm_hit_a, dm_hit_b;
    logic     wb_hit_a, wb_hit_b;
    logic     ex_load;
    logic     run;
    logic     use_a, use_b;
    logic     stall, flush, bubble;
    hz_slot_t id_slot;
    hz_src_e  src_a, src_b;

    assign run   = (state == HZ_ST_RUN);
    assign use_a = id_use_a && (id_rs != '0);
    assign use_b = id_use_b && (id_rt != '0);

    // Halt outranks branch, branch outranks load-use stall.
    assign stall = run && !halt_ex && !load_pc && ex_load &&
                   ((use_a && ex_hit_a) || (use_b && ex_hit_b));
    assign flush = run && !halt_ex && load_pc;

    // Anything other than a clean RUN advance puts a bubble into EX.
    assign bubble = !run || halt_ex || load_pc || stall;

    always_comb begin
        id_slot         = '0;
        id_slot.valid   = id_w_en && !bubble;
        id_slot.req_w   = id_req_w;
        id_slot.is_load = id_is_load;
    end

    hazard_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .id_slot  (id_slot),
        .rs       (id_rs),
        .rt       (id_rt),
        .ex_hit_a (ex_hit_a),
        .ex_hit_b (ex_hit_b),
        .dm_hit_a (dm_hit_a),
        .dm_hit_b (dm_hit_b),
        .wb_hit_a (wb_hit_a),
        .wb_hit_b (wb_hit_b),
        .ex_load  (ex_load)
    );

    // State register; frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_ST_RUN;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next state and pipeline enable/clear decode.
    always_comb begin
        state_nxt = state;
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        if_id_clr = 1'b0;
        id_ex_en  = 1'b0;
        id_ex_clr = 1'b0;
        if (en) begin
            case (state)
                HZ_ST_RUN: begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    id_ex_en = 1'b1;
                    if (halt_ex) begin
                        state_nxt = HZ_ST_HALTING;
                        pc_en     = 1'b0;
                        if_id_clr = 1'b1;
                        id_ex_clr = 1'b1;
                    end else if (load_pc) begin
                        if_id_clr = 1'b1;
                        id_ex_clr = 1'b1;
                    end else if (stall) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_clr = 1'b1;
                    end
                end
                HZ_ST_HALTING: begin
                    if_id_en  = 1'b1;
                    if_id_clr = 1'b1;
                    id_ex_en  = 1'b1;
                    id_ex_clr = 1'b1;
                    if (halt_wb) begin
                        state_nxt = HZ_ST_HALTED;
                    end
                end
                HZ_ST_HALTED: begin
                    state_nxt = HZ_ST_HALTED;
                end
                default: begin
                    state_nxt = HZ_ST_RUN;
                end
            endcase
        end
    end

    assign halted = (state == HZ_ST_HALTED);

    // Forwarding is only meaningful while instructions are still issuing.
    always_comb begin
        src_a = SRC_OLD;
        src_b = SRC_OLD;
        if (run) begin
            src_a = fwd_pick(use_a, ex_hit_a, dm_hit_a, wb_hit_a);
            src_b = fwd_pick(use_b, ex_hit_b, dm_hit_b, wb_hit_b);
        end
    end

    always_comb begin
        fwd_a = MUX_EX_REDIR_A_OLD;
        case (src_a)
            SRC_EX:  fwd_a = MUX_EX_REDIR_A_EX;
            SRC_DM:  fwd_a = MUX_EX_REDIR_A_DM;
            default: fwd_a = MUX_EX_REDIR_A_OLD;
        endcase
    end

    always_comb begin
        fwd_b = MUX_EX_REDIR_B_OLD;
        case (src_b)
            SRC_EX:  fwd_b = MUX_EX_REDIR_B_EX;
            SRC_DM:  fwd_b = MUX_EX_REDIR_B_DM;
            default: fwd_b = MUX_EX_REDIR_B_OLD;
        endcase
    end

    // Saturating perf counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (en) begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_BIT'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_BIT'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench with a queue scoreboard for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] NRM = 5'b11010; // {pc_en,if_id_en,if_id_clr,id_ex_en,id_ex_clr}
    localparam logic [4:0] STL = 5'b00011;
    localparam logic [4:0] FLS = 5'b11111;
    localparam logic [4:0] HLG = 5'b01111;
    localparam logic [4:0] OFF = 5'b00000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  id_rs, id_rt, id_req_w;
    logic        id_use_a, id_use_b, id_w_en, id_is_load;
    logic        load_pc, halt_ex, halt_wb;
    logic        pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr;
    logic [1:0]  fwd_a, fwd_b;
    logic        halted;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct packed {
        int          id;
        logic [4:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        h;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl #(.CNT_BIT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_a   (id_use_a),
        .id_use_b   (id_use_b),
        .id_w_en    (id_w_en),
        .id_req_w   (id_req_w),
        .id_is_load (id_is_load),
        .load_pc    (load_pc),
        .halt_ex    (halt_ex),
        .halt_wb    (halt_wb),
        .pc_en      (pc_en),
        .if_id_en   (if_id_en),
        .if_id_clr  (if_id_clr),
        .id_ex_en   (id_ex_en),
        .id_ex_clr  (id_ex_clr),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .halted     (halted),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, expv);
        end
    endtask

    // Drive one cycle of ID/EX inputs and queue the hand-computed response.
    task automatic v(input int id, input int r, input int e,
                     input int rs, input int ua, input int rt, input int ub,
                     input int we, input int rw, input int ld,
                     input int lp, input int hx, input int hw,
                     input logic [4:0] ctl, input int fa, input int fb, input int h,
                     input int sc, input int fc);
        exp_t x;
        x.id  = id;
        x.ctl = ctl;
        x.fa  = 2'(fa);
        x.fb  = 2'(fb);
        x.h   = 1'(h);
        x.sc  = 16'(sc);
        x.fc  = 16'(fc);
        @(negedge clk);
        rst        = 1'(r);
        en         = 1'(e);
        id_rs      = 5'(rs);
        id_use_a   = 1'(ua);
        id_rt      = 5'(rt);
        id_use_b   = 1'(ub);
        id_w_en    = 1'(we);
        id_req_w   = 5'(rw);
        id_is_load = 1'(ld);
        load_pc    = 1'(lp);
        halt_ex    = 1'(hx);
        halt_wb    = 1'(hw);
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are combinational, sampled mid-low-phase after inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ctl",       e.id, 32'({pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr}), 32'(e.ctl));
                chk("fwd_a",     e.id, 32'(fwd_a), 32'(e.fa));
                chk("fwd_b",     e.id, 32'(fwd_b), 32'(e.fb));
                chk("halted",    e.id, 32'(halted), 32'(e.h));
                chk("stall_cnt", e.id, 32'(stall_cnt), 32'(e.sc));
                chk("flush_cnt", e.id, 32'(flush_cnt), 32'(e.fc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1;
        id_rs = '0; id_rt = '0; id_req_w = '0;
        id_use_a = 1'b0; id_use_b = 1'b0; id_w_en = 1'b0; id_is_load = 1'b0;
        load_pc = 1'b0; halt_ex = 1'b0; halt_wb = 1'b0;
        repeat (2) @(posedge clk);

        //  id  r e  rs ua rt ub we rw ld lp hx hw  ctl  fa fb h  sc fc
        v(1,  0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 0,0);   // reset state
        // load-use: lw $8 then add $9,$8,$8
        v(2,  0,1, 0, 1, 0, 0, 1, 8, 1, 0,0,0, NRM, 0,0,0, 0,0);
        v(3,  0,1, 8, 1, 8, 1, 1, 9, 0, 0,0,0, STL, 1,1,0, 0,0);
        v(4,  0,1, 8, 1, 8, 1, 1, 9, 0, 0,0,0, NRM, 2,2,0, 1,0);
        // forwarding distance 1 / 2 / 3
        v(5,  0,1, 0, 1, 0, 0, 1,10, 0, 0,0,0, NRM, 0,0,0, 1,0);
        v(6,  0,1,10, 1, 0, 0, 1,11, 0, 0,0,0, NRM, 1,0,0, 1,0);
        v(7,  0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 1,0);
        v(8,  0,1,11, 1,10, 1, 1,12, 0, 0,0,0, NRM, 2,0,0, 1,0);
        v(9,  0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 1,0);
        v(10, 0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 1,0);
        v(11, 0,1,12, 1,12, 1, 0, 0, 0, 0,0,0, NRM, 0,0,0, 1,0);
        // EX match has priority over DM match
        v(12, 0,1, 0, 0, 0, 0, 1,13, 0, 0,0,0, NRM, 0,0,0, 1,0);
        v(13, 0,1, 0, 0, 0, 0, 1,13, 0, 0,0,0, NRM, 0,0,0, 1,0);
        v(14, 0,1,13, 1, 0, 0, 0, 0, 0, 0,0,0, NRM, 1,0,0, 1,0);
        // load-use hazard coinciding with a taken branch
        v(15, 0,1, 0, 0, 0, 0, 1,14, 1, 0,0,0, NRM, 0,0,0, 1,0);
        v(16, 0,1,14, 1, 0, 0, 1,15, 0, 1,0,0, FLS, 1,0,0, 1,0);
        v(17, 0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 1,1);
        // $0 is never tracked
        v(18, 0,1, 0, 0, 0, 0, 1, 0, 1, 0,0,0, NRM, 0,0,0, 1,1);
        v(19, 0,1, 0, 1, 0, 1, 1, 0, 0, 0,0,0, NRM, 0,0,0, 1,1);
        v(20, 0,1, 0, 1, 0, 1, 0, 0, 0, 0,0,0, NRM, 0,0,0, 1,1);
        v(21, 0,1, 0, 0, 0, 0, 0, 0, 0, 1,0,0, FLS, 0,0,0, 1,1);
        v(22, 0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 1,2);
        // en=0 for 5 cycles with a load-use pending
        v(23, 0,1, 0, 0, 0, 0, 1,15, 1, 0,0,0, NRM, 0,0,0, 1,2);
        for (int i = 0; i < 5; i++)
            v(24 + i, 0,0,15, 1, 0, 0, 1,16, 0, 0,0,0, OFF, 1,0,0, 1,2);
        v(29, 0,1,15, 1, 0, 0, 1,16, 0, 0,0,0, STL, 1,0,0, 1,2);
        v(30, 0,1,15, 1, 0, 0, 1,16, 0, 0,0,0, NRM, 2,0,0, 2,2);
        // reset during a stall
        v(31, 0,1, 0, 0, 0, 0, 1,17, 1, 0,0,0, NRM, 0,0,0, 2,2);
        v(32, 1,1,17, 1, 0, 0, 1,18, 0, 0,0,0, STL, 1,0,0, 2,2);
        v(33, 0,1,17, 1, 0, 0, 1,18, 0, 0,0,0, NRM, 0,0,0, 0,0);
        // halt drain: halt_ex, HALTING x2, halt_wb, then HALTED
        v(34, 0,1, 0, 0, 0, 0, 1,20, 0, 0,0,0, NRM, 0,0,0, 0,0);
        v(35, 0,1, 0, 0, 0, 0, 0, 0, 0, 1,1,0, HLG, 0,0,0, 0,0);
        v(36, 0,1,20, 1, 0, 0, 0, 0, 0, 0,0,0, HLG, 0,0,0, 0,0);
        v(37, 0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,1, HLG, 0,0,0, 0,0);
        v(38, 0,1, 0, 0, 0, 0, 0, 0, 0, 1,0,0, OFF, 0,0,1, 0,0);
        v(39, 0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, OFF, 0,0,1, 0,0);
        // reset out of HALTED, then reset during HALTING
        v(40, 1,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, OFF, 0,0,1, 0,0);
        v(41, 0,1, 0, 0, 0, 0, 0, 0, 0, 0,1,0, HLG, 0,0,0, 0,0);
        v(42, 1,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, HLG, 0,0,0, 0,0);
        v(43, 0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 0,0);
        // unused sources never stall against a load
        v(44, 0,1, 0, 0, 0, 0, 1,21, 1, 0,0,0, NRM, 0,0,0, 0,0);
        v(45, 0,1,21, 0,21, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 0,0);
        v(46, 0,1, 0, 0, 0, 0, 0, 0, 0, 0,0,0, NRM, 0,0,0, 0,0);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #5;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
